// File: rtl/song_sequencer.sv
// Steps the confirmed song's note chart from a 1-cycle-latency ROM while the game is in PLAY.
// It drives the lane notes and scores button hits. Define SONG_SEQUENCER_MISS_COUNT_EN to add the miss_count output.
module song_sequencer #(
  parameter int TICKS_PER_STEP = 6250000,
  parameter int STEP_W         = 6,
  parameter int SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         state,
  input  logic [1:0]         song_confirm,
  input  logic               red_button,
  input  logic               blue_button,
  input  logic               yellow_button,
  output logic               chart_rd,
  output logic [STEP_W+1:0]  chart_addr,
  input  logic [3:0]         chart_data,
  output logic [2:0]         lanes,
  output logic [STEP_W-1:0]  step_idx,
  output logic [SCORE_W-1:0] score,
  output logic               finish,
  output logic               busy
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
  ,
  output logic [SCORE_W-1:0] miss_count
`endif
);
  localparam int                TICK_W    = $clog2(TICKS_PER_STEP);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_STEP - 1);
  localparam logic [1:0]        ST_PLAY   = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_SHOW, S_DONE} fsm_t;

  fsm_t               fsm_q, fsm_d;
  logic [1:0]         song_q, song_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [2:0]         lanes_q, lanes_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [2:0]         hit_q, hit_d;
  logic               finish_q, finish_d;
  logic [2:0]         btn_q;
  logic [2:0]         btn, press, hit_now;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
  logic [SCORE_W-1:0] miss_q, miss_d;
`endif

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input logic [1:0] n);
    logic [SCORE_W:0] s;
    s = {1'b0, a} + (SCORE_W+1)'(n);
    return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
  endfunction

  // Lane 0 is red. A press is the first cycle a level is seen high.
  assign btn     = {yellow_button, blue_button, red_button};
  assign press   = btn & ~btn_q;
  assign hit_now = (fsm_q == S_SHOW) ? (press & lanes_q & ~hit_q) : 3'b000;

  always_comb begin
    fsm_d    = fsm_q;
    song_d   = song_q;
    step_d   = step_q;
    lanes_d  = lanes_q;
    score_d  = score_q;
    tick_d   = tick_q;
    hit_d    = hit_q;
    finish_d = 1'b0;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
    miss_d   = miss_q;
`endif
    if (song_confirm != 2'd0) song_d = song_confirm;
    unique case (fsm_q)
      S_IDLE: begin
        if (state == ST_PLAY && song_q != 2'd0) begin
          step_d  = '0;
          score_d = '0;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
          miss_d  = '0;
`endif
          fsm_d   = S_FETCH;
        end
      end
      S_FETCH: begin
        if (state != ST_PLAY) begin
          fsm_d   = S_IDLE;
          lanes_d = '0;
        end else begin
          fsm_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (state != ST_PLAY) begin
          fsm_d   = S_IDLE;
          lanes_d = '0;
        end else if (chart_data[3]) begin
          lanes_d  = '0;
          fsm_d    = S_DONE;
          finish_d = 1'b1;
        end else begin
          lanes_d = chart_data[2:0];
          hit_d   = '0;
          tick_d  = '0;
          fsm_d   = S_SHOW;
        end
      end
      S_SHOW: begin
        // Scoring applies on every SHOW cycle, including the exit cycle.
        score_d = sat_add(score_q, popcnt3(hit_now));
        hit_d   = hit_q | hit_now;
        tick_d  = tick_q + TICK_W'(1);
        if (state != ST_PLAY) begin
          fsm_d   = S_IDLE;
          lanes_d = '0;
        end else if (tick_q == TICK_LAST) begin
          lanes_d = '0;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
          miss_d  = sat_add(miss_q, popcnt3(lanes_q & ~hit_d));
`endif
          if (step_q == '1) begin
            fsm_d    = S_DONE;
            finish_d = 1'b1;
          end else begin
            step_d = step_q + STEP_W'(1);
            fsm_d  = S_FETCH;
          end
        end
      end
      S_DONE: begin
        song_d = song_confirm;
        fsm_d  = S_IDLE;
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q    <= S_IDLE;
      song_q   <= '0;
      step_q   <= '0;
      lanes_q  <= '0;
      score_q  <= '0;
      tick_q   <= '0;
      hit_q    <= '0;
      finish_q <= 1'b0;
      btn_q    <= '0;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
      miss_q   <= '0;
`endif
    end else begin
      fsm_q    <= fsm_d;
      song_q   <= song_d;
      step_q   <= step_d;
      lanes_q  <= lanes_d;
      score_q  <= score_d;
      tick_q   <= tick_d;
      hit_q    <= hit_d;
      finish_q <= finish_d;
      btn_q    <= btn;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
      miss_q   <= miss_d;
`endif
    end
  end

  assign chart_rd   = (fsm_q == S_FETCH);
  assign chart_addr = chart_rd ? {song_q, step_q} : '0;
  assign busy       = (fsm_q == S_FETCH) || (fsm_q == S_WAIT) || (fsm_q == S_SHOW);
  assign lanes      = lanes_q;
  assign step_idx   = step_q;
  assign score      = score_q;
  assign finish     = finish_q;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: DUT A (STEP_W=6, SCORE_W=8) and DUT B (STEP_W=2, SCORE_W=2), both TICKS_PER_STEP=4.
// Expected timelines and scores are computed from the chart and the button levels by a step-window model.
module tb_song_sequencer;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] state, song_confirm;
  logic       red, blue, yellow;

  logic       a_rd, a_fin, a_busy;
  logic [7:0] a_addr, a_score;
  logic [3:0] a_data;
  logic [2:0] a_lanes;
  logic [5:0] a_step;
  logic       b_rd, b_fin, b_busy;
  logic [3:0] b_addr, b_data;
  logic [1:0] b_score, b_step;
  logic [2:0] b_lanes;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
  logic [7:0] a_miss;
  logic [1:0] b_miss;
`endif

  logic [3:0] rom_a [256];
  logic [3:0] rom_b [16];
  always_ff @(posedge clk) begin
    if (a_rd) a_data <= rom_a[a_addr];
    if (b_rd) b_data <= rom_b[b_addr];
  end

  song_sequencer #(.TICKS_PER_STEP(T), .STEP_W(6), .SCORE_W(8)) dut_a (
    .clk(clk), .rst(rst), .state(state), .song_confirm(song_confirm),
    .red_button(red), .blue_button(blue), .yellow_button(yellow),
    .chart_rd(a_rd), .chart_addr(a_addr), .chart_data(a_data),
    .lanes(a_lanes), .step_idx(a_step), .score(a_score), .finish(a_fin), .busy(a_busy)
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
    , .miss_count(a_miss)
`endif
  );

  song_sequencer #(.TICKS_PER_STEP(T), .STEP_W(2), .SCORE_W(2)) dut_b (
    .clk(clk), .rst(rst), .state(state), .song_confirm(song_confirm),
    .red_button(red), .blue_button(blue), .yellow_button(yellow),
    .chart_rd(b_rd), .chart_addr(b_addr), .chart_data(b_data),
    .lanes(b_lanes), .step_idx(b_step), .score(b_score), .finish(b_fin), .busy(b_busy)
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
    , .miss_count(b_miss)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] chart [64];
  logic [2:0] lvl   [128];
  integer obs_lanes[128], obs_rd[128], obs_addr[128], obs_fin[128], obs_step[128], obs_busy[128];
  integer exp_lanes[128], exp_rd[128], exp_addr[128], exp_fin[128], exp_step[128], exp_busy[128];
  integer obs_score, obs_miss, exp_score, exp_miss;

  task automatic do_reset();
    rst = 1'b1; state = 2'd0; song_confirm = 2'd0; {yellow, blue, red} = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic load_rom(input int s);
    for (int k = 0; k < 64; k++) rom_a[{s[1:0], k[5:0]}] = chart[k];
    for (int k = 0; k < 4; k++)  rom_b[{s[1:0], k[1:0]}] = chart[k];
  endtask

  // Confirm song s, enter PLAY, record ncyc cycles of the selected DUT. Cycle 0 is the first FETCH cycle.
  task automatic run_play(input int which, input int s, input int ncyc);
    do_reset();
    load_rom(s);
    song_confirm = s[1:0];
    @(posedge clk); #1;
    song_confirm = 2'd0;
    state = 2'd2;
    @(posedge clk);
    for (int c = 0; c < ncyc; c++) begin
      #1;
      if (which == 0) begin
        obs_lanes[c] = a_lanes; obs_rd[c] = a_rd; obs_addr[c] = a_addr;
        obs_fin[c] = a_fin; obs_step[c] = a_step; obs_busy[c] = a_busy;
      end else begin
        obs_lanes[c] = b_lanes; obs_rd[c] = b_rd; obs_addr[c] = b_addr;
        obs_fin[c] = b_fin; obs_step[c] = b_step; obs_busy[c] = b_busy;
      end
      {yellow, blue, red} = lvl[c];
      @(posedge clk);
    end
    #1;
    obs_score = (which == 0) ? a_score : b_score;
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
    obs_miss = (which == 0) ? a_miss : b_miss;
`else
    obs_miss = 0;
`endif
    {yellow, blue, red} = 3'b000;
    state = 2'd1;
  endtask

  // Each step k shows for cycles 2+k*(T+2) .. 5+k*(T+2); a lit lane is hit if its level rises inside that window.
  task automatic model(input int which, input int s, input int ncyc);
    int m, smax, n, done, k, off, hits, miss;
    bit marker, h;
    m = (which == 0) ? 64 : 4;
    smax = (which == 0) ? 255 : 3;
    n = 0; marker = 0;
    while (n < m) begin
      if (chart[n][3]) begin marker = 1; break; end
      n++;
    end
    done = marker ? n*(T+2) + 2 : n*(T+2);
    for (int c = 0; c < ncyc; c++) begin
      exp_rd[c]   = (c < done && c % (T+2) == 0) ? 1 : 0;
      exp_addr[c] = exp_rd[c] ? s*m + c/(T+2) : 0;
      exp_fin[c]  = (c == done) ? 1 : 0;
      exp_busy[c] = (c < done) ? 1 : 0;
      k = c/(T+2);
      exp_step[c] = marker ? ((k < n) ? k : n) : ((k < n-1) ? k : n-1);
      exp_lanes[c] = 0;
      if (c >= 2) begin
        k = (c-2)/(T+2); off = (c-2)%(T+2);
        if (k < n && off < T) exp_lanes[c] = chart[k][2:0];
      end
    end
    hits = 0; miss = 0;
    for (int st = 0; st < n; st++)
      for (int i = 0; i < 3; i++)
        if (chart[st][i]) begin
          h = 0;
          for (int c = 2 + st*(T+2); c < 2 + st*(T+2) + T; c++)
            if (lvl[c][i] && !(c > 0 && lvl[c-1][i])) h = 1;
          if (h) hits++; else miss++;
        end
    exp_score = (hits > smax) ? smax : hits;
    exp_miss  = (miss > smax) ? smax : miss;
  endtask

  task automatic clear_stim();
    for (int k = 0; k < 64; k++) chart[k] = 4'h0;
    for (int c = 0; c < 128; c++) lvl[c] = 3'b000;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if ({a_lanes, a_step, a_score, a_fin, a_busy, a_rd, a_addr} !== '0) begin
      errors++; $display("FAIL reset_a outputs got %h exp 0", {a_lanes, a_step, a_score, a_fin, a_busy, a_rd, a_addr});
    end
    if ({b_lanes, b_step, b_score, b_fin, b_busy, b_rd, b_addr} !== '0) begin
      errors++; $display("FAIL reset_b outputs got %h exp 0", {b_lanes, b_step, b_score, b_fin, b_busy, b_rd, b_addr});
    end
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
    if (a_miss !== 8'd0) begin errors++; $display("FAIL reset_a miss got %0d exp 0", a_miss); end
`else
    if (a_score !== 8'd0) begin errors++; $display("FAIL reset_a score got %0d exp 0", a_score); end
`endif
    if (b_score !== 2'd0) begin errors++; $display("FAIL reset_b score got %0d exp 0", b_score); end
  endtask

  task automatic test_normal_play();
    int nfin;
    clear_stim();
    chart[0] = 4'b0101; chart[1] = 4'b0010; chart[2] = 4'b1000;
    run_play(0, 2, 24);
    model(0, 2, 24);
    nfin = 0;
    for (int c = 0; c < 24; c++) begin
      checks += 6;
      nfin += obs_fin[c];
      if (obs_lanes[c] !== exp_lanes[c]) begin errors++; $display("FAIL normal lanes c=%0d got %0d exp %0d", c, obs_lanes[c], exp_lanes[c]); end
      if (obs_rd[c]    !== exp_rd[c])    begin errors++; $display("FAIL normal chart_rd c=%0d got %0d exp %0d", c, obs_rd[c], exp_rd[c]); end
      if (obs_addr[c]  !== exp_addr[c])  begin errors++; $display("FAIL normal addr c=%0d got %0h exp %0h", c, obs_addr[c], exp_addr[c]); end
      if (obs_fin[c]   !== exp_fin[c])   begin errors++; $display("FAIL normal finish c=%0d got %0d exp %0d", c, obs_fin[c], exp_fin[c]); end
      if (obs_step[c]  !== exp_step[c])  begin errors++; $display("FAIL normal step c=%0d got %0d exp %0d", c, obs_step[c], exp_step[c]); end
      if (obs_busy[c]  !== exp_busy[c])  begin errors++; $display("FAIL normal busy c=%0d got %0d exp %0d", c, obs_busy[c], exp_busy[c]); end
    end
    checks += 3;
    if (obs_addr[6] !== 8'h81) begin errors++; $display("FAIL normal addr_step1 got %0h exp 81", obs_addr[6]); end
    if (nfin !== 1) begin errors++; $display("FAIL normal finish_count got %0d exp 1", nfin); end
    if (obs_score !== 0) begin errors++; $display("FAIL normal score got %0d exp 0", obs_score); end
  endtask

  task automatic test_scoring();
    clear_stim();
    chart[0] = 4'b0101; chart[1] = 4'b0010; chart[2] = 4'b1000;
    // red: press, hold, release, re-press in step 0; yellow hits; blue press while its lane is dark
    lvl[2] = 3'b001; lvl[3] = 3'b101; lvl[4] = 3'b110; lvl[5] = 3'b001;
    run_play(0, 2, 24);
    model(0, 2, 24);
    checks += 2;
    if (obs_score !== 2) begin errors++; $display("FAIL scoring score got %0d exp 2", obs_score); end
    if (exp_score !== obs_score) begin errors++; $display("FAIL scoring model_score got %0d exp %0d", obs_score, exp_score); end
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
    checks++;
    if (obs_miss !== 1) begin errors++; $display("FAIL scoring miss got %0d exp 1", obs_miss); end
`endif
  endtask

  task automatic test_abort();
    int fin_seen;
    clear_stim();
    chart[0] = 4'b0101; chart[1] = 4'b0010; chart[2] = 4'b1000;
    do_reset();
    load_rom(2);
    song_confirm = 2'd2; @(posedge clk); #1; song_confirm = 2'd0;
    state = 2'd2;
    @(posedge clk);
    fin_seen = 0;
    for (int c = 0; c < 18; c++) begin
      #1;
      if (a_fin) fin_seen++;
      if (c == 9) begin
        checks += 2;
        if (a_lanes !== 3'b010) begin errors++; $display("FAIL abort pre_lanes got %b exp 010", a_lanes); end
        if (a_score !== 8'd1)   begin errors++; $display("FAIL abort pre_score got %0d exp 1", a_score); end
      end
      if (c == 10) begin
        checks += 4;
        if (a_lanes !== 3'b000) begin errors++; $display("FAIL abort lanes got %b exp 000", a_lanes); end
        if (a_busy !== 1'b0)    begin errors++; $display("FAIL abort busy got %0d exp 0", a_busy); end
        if (a_rd !== 1'b0)      begin errors++; $display("FAIL abort chart_rd got %0d exp 0", a_rd); end
        if (a_score !== 8'd1)   begin errors++; $display("FAIL abort score_held got %0d exp 1", a_score); end
      end
      if (c == 15) begin
        checks += 3;
        if (a_rd !== 1'b1)      begin errors++; $display("FAIL abort restart_rd got %0d exp 1", a_rd); end
        if (a_addr !== 8'h80)   begin errors++; $display("FAIL abort restart_addr got %0h exp 80", a_addr); end
        if (a_score !== 8'd0)   begin errors++; $display("FAIL abort restart_score got %0d exp 0", a_score); end
      end
      red = (c == 2);
      state = (c >= 9 && c < 14) ? 2'd1 : 2'd2;
      @(posedge clk);
    end
    checks++;
    if (fin_seen !== 0) begin errors++; $display("FAIL abort finish_seen got %0d exp 0", fin_seen); end
  endtask

  task automatic test_no_song();
    int rd_seen;
    do_reset();
    state = 2'd2;
    rd_seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (a_rd || b_rd || a_busy || b_busy) rd_seen++;
    end
    checks++;
    if (rd_seen !== 0) begin errors++; $display("FAIL no_song rd_or_busy_cycles got %0d exp 0", rd_seen); end
  endtask

  task automatic test_no_end_marker();
    clear_stim();
    for (int k = 0; k < 4; k++) chart[k] = 4'b0001;
    run_play(1, 1, 28);
    model(1, 1, 28);
    for (int c = 0; c < 28; c++) begin
      checks += 5;
      if (obs_lanes[c] !== exp_lanes[c]) begin errors++; $display("FAIL nomark lanes c=%0d got %0d exp %0d", c, obs_lanes[c], exp_lanes[c]); end
      if (obs_rd[c]    !== exp_rd[c])    begin errors++; $display("FAIL nomark chart_rd c=%0d got %0d exp %0d", c, obs_rd[c], exp_rd[c]); end
      if (obs_addr[c]  !== exp_addr[c])  begin errors++; $display("FAIL nomark addr c=%0d got %0h exp %0h", c, obs_addr[c], exp_addr[c]); end
      if (obs_fin[c]   !== exp_fin[c])   begin errors++; $display("FAIL nomark finish c=%0d got %0d exp %0d", c, obs_fin[c], exp_fin[c]); end
      if (obs_step[c]  !== exp_step[c])  begin errors++; $display("FAIL nomark step c=%0d got %0d exp %0d", c, obs_step[c], exp_step[c]); end
    end
    checks += 2;
    if (obs_addr[18] !== 4'h7) begin errors++; $display("FAIL nomark last_addr got %0h exp 7", obs_addr[18]); end
    if (obs_fin[24] !== 1)     begin errors++; $display("FAIL nomark finish_at_24 got %0d exp 1", obs_fin[24]); end
  endtask

  task automatic test_saturation();
    clear_stim();
    chart[0] = 4'b0111; chart[1] = 4'b0111; chart[2] = 4'b0111; chart[3] = 4'b0000;
    for (int c = 0; c < 26; c++) lvl[c] = (c % 2 == 0) ? 3'b111 : 3'b000;
    run_play(1, 3, 28);
    model(1, 3, 28);
    checks += 2;
    if (obs_score !== 3) begin errors++; $display("FAIL saturation score got %0d exp 3", obs_score); end
    if (obs_score !== exp_score) begin errors++; $display("FAIL saturation model_score got %0d exp %0d", obs_score, exp_score); end
  endtask

  task automatic test_reset_mid_show();
    int rd_seen;
    clear_stim();
    chart[0] = 4'b0101; chart[1] = 4'b0010; chart[2] = 4'b1000;
    do_reset();
    load_rom(2);
    song_confirm = 2'd2; @(posedge clk); #1; song_confirm = 2'd0;
    state = 2'd2;
    @(posedge clk);
    rd_seen = 0;
    for (int c = 0; c < 13; c++) begin
      #1;
      if (c == 3) begin
        checks += 2;
        if (a_score !== 8'd1)   begin errors++; $display("FAIL rst_mid pre_score got %0d exp 1", a_score); end
        if (a_lanes !== 3'b101) begin errors++; $display("FAIL rst_mid pre_lanes got %b exp 101", a_lanes); end
      end
      if (c == 4) begin
        checks++;
        if ({a_lanes, a_step, a_score, a_fin, a_busy, a_rd, a_addr} !== '0) begin
          errors++; $display("FAIL rst_mid outputs got %h exp 0", {a_lanes, a_step, a_score, a_fin, a_busy, a_rd, a_addr});
        end
      end
      if (c >= 5 && a_rd) rd_seen++;
      red = (c == 2);
      rst = (c == 3);
      @(posedge clk);
    end
    checks++;
    if (rd_seen !== 0) begin errors++; $display("FAIL rst_mid song_cleared rd_cycles got %0d exp 0", rd_seen); end
  endtask

  task automatic test_random();
    int s, n, ncyc;
    logic [2:0] cur;
    for (int it = 0; it < 6; it++) begin
      clear_stim();
      s = $urandom_range(1, 3);
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) chart[k] = {1'b0, 3'($urandom_range(0, 7))};
      chart[n] = 4'b1000;
      ncyc = n*(T+2) + 6;
      cur = 3'b000;
      for (int c = 0; c < ncyc; c++) begin
        for (int i = 0; i < 3; i++) if ($urandom_range(0, 2) == 0) cur[i] = ~cur[i];
        lvl[c] = cur;
      end
      run_play(0, s, ncyc);
      model(0, s, ncyc);
      for (int c = 0; c < ncyc; c++) begin
        checks += 4;
        if (obs_lanes[c] !== exp_lanes[c]) begin errors++; $display("FAIL random lanes it=%0d c=%0d got %0d exp %0d", it, c, obs_lanes[c], exp_lanes[c]); end
        if (obs_addr[c]  !== exp_addr[c])  begin errors++; $display("FAIL random addr it=%0d c=%0d got %0h exp %0h", it, c, obs_addr[c], exp_addr[c]); end
        if (obs_fin[c]   !== exp_fin[c])   begin errors++; $display("FAIL random finish it=%0d c=%0d got %0d exp %0d", it, c, obs_fin[c], exp_fin[c]); end
        if (obs_busy[c]  !== exp_busy[c])  begin errors++; $display("FAIL random busy it=%0d c=%0d got %0d exp %0d", it, c, obs_busy[c], exp_busy[c]); end
      end
      checks++;
      if (obs_score !== exp_score) begin errors++; $display("FAIL random score it=%0d got %0d exp %0d", it, obs_score, exp_score); end
`ifdef SONG_SEQUENCER_MISS_COUNT_EN
      checks++;
      if (obs_miss !== exp_miss) begin errors++; $display("FAIL random miss it=%0d got %0d exp %0d", it, obs_miss, exp_miss); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_normal_play();
    test_scoring();
    test_abort();
    test_no_song();
    test_no_end_marker();
    test_saturation();
    test_reset_mid_show();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
